// File: rtl/data_mem_arb.sv
// Two-port (core / auxiliary) round-robin arbiter in front of a single-ported data memory.
// Each access takes two cycles: grant plus memory strobe, then the completion pulse.
module data_mem_arb #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              core_req_i,
    input  logic [AWIDTH-1:0] core_addr_i,
    input  logic [3:0]        core_write_ctrl_i,
    input  logic [DWIDTH-1:0] core_write_data_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [DWIDTH-1:0] core_read_data_o,

    input  logic              aux_req_i,
    input  logic [AWIDTH-1:0] aux_addr_i,
    input  logic [3:0]        aux_write_ctrl_i,
    input  logic [DWIDTH-1:0] aux_write_data_i,
    output logic              aux_gnt_o,
    output logic              aux_rvalid_o,
    output logic [DWIDTH-1:0] aux_read_data_o,

    output logic              mem_en_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [3:0]        mem_write_ctrl_o,
    output logic [DWIDTH-1:0] mem_write_data_o,
    input  logic [DWIDTH-1:0] mem_read_data_i
);

    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] RESP       = 1'b1;
    localparam logic       OWNER_CORE = 1'b0;
    localparam logic       OWNER_AUX  = 1'b1;

    logic [0:0] state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       owner_q, owner_d;
    logic       is_read_q, is_read_d;
    logic       win_aux;

    // Aux wins when alone, or on a tie when the core was served last.
    assign win_aux = aux_req_i & (~core_req_i | (last_owner_q == OWNER_CORE));

    always_comb begin
        state_d          = state_q;
        last_owner_d     = last_owner_q;
        owner_d          = owner_q;
        is_read_d        = is_read_q;
        core_gnt_o       = 1'b0;
        aux_gnt_o        = 1'b0;
        core_rvalid_o    = 1'b0;
        aux_rvalid_o     = 1'b0;
        core_read_data_o = '0;
        aux_read_data_o  = '0;
        mem_en_o         = 1'b0;
        mem_addr_o       = '0;
        mem_write_ctrl_o = 4'b0000;
        mem_write_data_o = '0;

        case (state_q)
            IDLE: begin
                if (core_req_i || aux_req_i) begin
                    mem_en_o = 1'b1;
                    if (win_aux) begin
                        aux_gnt_o        = 1'b1;
                        mem_addr_o       = aux_addr_i;
                        mem_write_ctrl_o = aux_write_ctrl_i;
                        mem_write_data_o = aux_write_data_i;
                    end else begin
                        core_gnt_o       = 1'b1;
                        mem_addr_o       = core_addr_i;
                        mem_write_ctrl_o = core_write_ctrl_i;
                        mem_write_data_o = core_write_data_i;
                    end
                    owner_d      = win_aux ? OWNER_AUX : OWNER_CORE;
                    last_owner_d = win_aux ? OWNER_AUX : OWNER_CORE;
                    is_read_d    = (mem_write_ctrl_o == 4'b0000);
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (owner_q == OWNER_AUX) begin
                    aux_rvalid_o = 1'b1;
                    if (is_read_q) aux_read_data_o = mem_read_data_i;
                end else begin
                    core_rvalid_o = 1'b1;
                    if (is_read_q) core_read_data_o = mem_read_data_i;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs must read as idle for the whole time reset is held, even with requests pending.
        if (!rst_n_i) begin
            core_gnt_o       = 1'b0;
            aux_gnt_o        = 1'b0;
            core_rvalid_o    = 1'b0;
            aux_rvalid_o     = 1'b0;
            core_read_data_o = '0;
            aux_read_data_o  = '0;
            mem_en_o         = 1'b0;
            mem_addr_o       = '0;
            mem_write_ctrl_o = 4'b0000;
            mem_write_data_o = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_AUX;
            owner_q      <= OWNER_CORE;
            is_read_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            is_read_q    <= is_read_d;
        end
    end

endmodule
